// File: rtl/ofm_writeback_ctrl_if.sv
// ofm_writeback_ctrl_if: OFM element stream into the writeback block and its global BRAM write port
interface ofm_writeback_ctrl_if #(parameter int DATA_W = 8, parameter int LANES = 16, parameter int ADDR_W = 32);
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic in_ready;
  logic [ADDR_W-1:0] wr_addr_global;
  logic [DATA_W*LANES-1:0] wr_data_global;
  logic we_global;
  logic wr_grant;
  modport slave (input in_valid, in_data, wr_grant, output in_ready, wr_addr_global, wr_data_global, we_global);
  modport master (output in_valid, in_data, wr_grant, input in_ready, wr_addr_global, wr_data_global, we_global);
endinterface

// File: rtl/ofm_writeback_ctrl.sv
// ofm_writeback_ctrl: packs streamed OFM elements into LANES-wide words, buffers them and writes them to global BRAM.
// Define OFM_WB_RELU_EN to clamp negative (signed) elements to zero before packing.
module ofm_writeback_ctrl #(
  parameter int DATA_W = 8,
  parameter int LANES = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic [ADDR_W-1:0] base_addr_ofm_i,
  input  logic [15:0] ofm_w_i,
  input  logic [15:0] ofm_h_i,
  input  logic [15:0] ofm_c_i,
  output logic busy_o,
  output logic done_o,
  ofm_writeback_ctrl_if.slave bus
);
  localparam int WW = DATA_W * LANES;
  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WW / 8);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] c_q, ch_q;
  logic [31:0] npix_q, pix_q;
  logic [LW-1:0] lane_q;
  logic [WW-1:0] word_q, word_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] elem;
  logic acc, push, pop, full, empty, last_lane, last_ch, last_pix, zero_dim;
`ifdef OFM_WB_RELU_EN
  assign elem = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
  assign elem = bus.in_data;
`endif
  assign full = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.we_global & bus.wr_grant;
  assign last_lane = lane_q == LW'(LANES - 1);
  assign last_ch = ch_q == c_q - 16'd1;
  assign last_pix = pix_q == npix_q - 32'd1;
  assign push = acc & (last_lane | last_ch);
  assign zero_dim = ofm_w_i == '0 || ofm_h_i == '0 || ofm_c_i == '0;
  // word_q holds only the lanes filled so far, so higher lanes of a channel-tail word stay zero
  assign word_d = word_q | (WW'(elem) << (int'(lane_q) * DATA_W));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = zero_dim ? DONE : RUN;
      RUN: if (acc && last_ch && last_pix) state_d = DRAIN;
      DRAIN: if (empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = state_q == RUN && !full;
    busy_o = state_q == RUN || state_q == DRAIN;
    done_o = state_q == DONE;
    bus.we_global = !empty;
    bus.wr_data_global = empty ? '0 : mem_q[rp_q];
    bus.wr_addr_global = addr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      c_q <= '0;
      npix_q <= '0;
      ch_q <= '0;
      pix_q <= '0;
      lane_q <= '0;
      word_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        c_q <= ofm_c_i;
        npix_q <= 32'(ofm_w_i) * 32'(ofm_h_i);
        addr_q <= base_addr_ofm_i;
        ch_q <= '0;
        pix_q <= '0;
        lane_q <= '0;
        word_q <= '0;
      end
      if (acc) begin
        lane_q <= push ? '0 : lane_q + 1'b1;
        word_q <= push ? '0 : word_d;
        ch_q <= last_ch ? '0 : ch_q + 16'd1;
        pix_q <= last_ch ? pix_q + 32'd1 : pix_q;
      end
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q <= rp_q + 1'b1;
        addr_q <= addr_q + STRIDE;
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= word_d;
endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
// tb_ofm_writeback_ctrl: scoreboard bench; expected writes come from a per-pixel channel-chunk model.
module tb_ofm_writeback_ctrl;
  localparam int DATA_W = 8, LANES = 16, FIFO_DEPTH = 4, ADDR_W = 32, WW = DATA_W * LANES;
  typedef struct {logic [ADDR_W-1:0] a; logic [WW-1:0] d;} wr_t;
  logic clk = 0, reset_n = 0, start = 0, busy, done;
  logic [ADDR_W-1:0] base = '0;
  logic [15:0] ow = '0, oh = '0, oc = '0;
  wr_t exp_q[$];
  logic [7:0] el_q[$];
  int checks = 0, errors = 0, done_cnt = 0, acc_cnt = 0, gmode = 0, vpct = 100;
  bit we_seen = 0;
  ofm_writeback_ctrl_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();
  ofm_writeback_ctrl #(.DATA_W(DATA_W), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .base_addr_ofm_i(base), .ofm_w_i(ow), .ofm_h_i(oh),
    .ofm_c_i(oc), .busy_o(busy), .done_o(done), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [7:0] relu(input logic [7:0] x);
`ifdef OFM_WB_RELU_EN
    return ($signed(x) < 0) ? 8'h00 : x;
`else
    return x;
`endif
  endfunction
  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.we_global) we_seen = 1;
    if (done) begin
      done_cnt++;
      chk("busy_in_done", WW'(busy), 0);
    end
    if (reset_n && bus.we_global && bus.wr_grant) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h", bus.wr_addr_global, bus.wr_data_global);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", WW'(bus.wr_addr_global), WW'(e.a));
        chk("wr_data", bus.wr_data_global, e.d);
      end
    end
  end
  initial begin
    bus.wr_grant = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.wr_grant = gmode == 0 ? 1'b1 : gmode == 1 ? 1'($urandom % 2) : 1'b0;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic build(input logic [ADDR_W-1:0] b, input int w, input int h, input int c, input bit rnd);
    int nw = (c + LANES - 1) / LANES;
    int k = 0;
    if (rnd) begin
      el_q.delete();
      repeat (w * h * c) el_q.push_back(8'($urandom));
    end
    for (int p = 0; p < w * h; p++)
      for (int g = 0; g < nw; g++) begin
        wr_t e;
        e.a = b + ADDR_W'(16 * k);
        e.d = '0;
        k++;
        for (int j = 0; j < LANES; j++)
          if (g * LANES + j < c) e.d[j*DATA_W +: DATA_W] = relu(el_q[p*c + g*LANES + j]);
        exp_q.push_back(e);
      end
  endtask
  task automatic do_start(input logic [ADDR_W-1:0] b, input int w, input int h, input int c);
    base = b;
    ow = 16'(w);
    oh = 16'(h);
    oc = 16'(c);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic feed(input int n);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 5000) begin
      bus.in_valid = ($urandom % 100) < 32'(vpct);
      bus.in_data = el_q[idx];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 0;
    chk("feed_count", WW'(idx), WW'(n));
  endtask
  task automatic wait_done(input int lim);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < lim) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", WW'(done_cnt - d0), 1);
    chk("sb_empty", WW'(exp_q.size()), 0);
    chk("busy_after", WW'(busy), 0);
  endtask
  task automatic run_job(input logic [ADDR_W-1:0] b, input int w, input int h, input int c, input int g, input bit rnd);
    gmode = g;
    build(b, w, h, c, rnd);
    do_start(b, w, h, c);
    feed(w * h * c);
    wait_done(3000);
  endtask
  task automatic chk_idle_outputs(input string n);
    chk({n, "_in_ready"}, WW'(bus.in_ready), 0);
    chk({n, "_we"}, WW'(bus.we_global), 0);
    chk({n, "_addr"}, WW'(bus.wr_addr_global), 0);
    chk({n, "_data"}, bus.wr_data_global, 0);
    chk({n, "_busy"}, WW'(busy), 0);
    chk({n, "_done"}, WW'(done), 0);
  endtask
  initial begin : main
    logic [ADDR_W-1:0] a0;
    logic [WW-1:0] d0;
    int dc;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset_n = 1;
    @(posedge clk);
    #1;
    el_q.delete();
    for (int i = 0; i < 16; i++) el_q.push_back(8'(i));
    run_job(32'h100, 1, 1, 16, 0, 0);
    fork
      run_job(32'h2000, 2, 1, 20, 0, 1);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("busy_run", WW'(busy), 1);
        start = 1;
        base = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        start = 0;
      end
    join
    gmode = 2;
    vpct = 100;
    acc_cnt = 0;
    build(32'h4000, 8, 1, 16, 1);
    do_start(32'h4000, 8, 1, 16);
    fork
      feed(128);
    join_none
    repeat (100) @(posedge clk);
    #1;
    chk("bp_accepted", WW'(acc_cnt), WW'(FIFO_DEPTH * 16));
    chk("bp_in_ready", WW'(bus.in_ready), 0);
    chk("bp_we", WW'(bus.we_global), 1);
    chk("bp_addr", WW'(bus.wr_addr_global), WW'(32'h4000));
    a0 = bus.wr_addr_global;
    d0 = bus.wr_data_global;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_addr_stable", WW'(bus.wr_addr_global), WW'(a0));
    chk("bp_data_stable", bus.wr_data_global, d0);
    gmode = 0;
    wait_done(3000);
    wait fork;
    we_seen = 0;
    dc = done_cnt;
    do_start(32'h5000, 3, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    do_start(32'h5000, 0, 2, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_done", WW'(done_cnt - dc), 2);
    chk("zero_no_we", WW'(we_seen), 0);
    el_q.delete();
    el_q.push_back(8'h80);
    el_q.push_back(8'h7F);
    run_job(32'h600, 1, 1, 2, 0, 0);
    vpct = 70;
    for (int r = 0; r < 6; r++)
      run_job(r == 2 ? 32'hFFFF_FFE0 : {$urandom_range(0, 32'hFFFF), 4'h0, 12'h0},
              $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 40), 1, 1);
    vpct = 100;
    gmode = 2;
    build(32'h7000, 2, 2, 16, 1);
    do_start(32'h7000, 2, 2, 16);
    feed(20);
    chk("pre_reset_we", WW'(bus.we_global), 1);
    reset_n = 0;
    #1;
    chk_idle_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;
    run_job(32'h8000, 1, 2, 33, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
